// File: rtl/mcode_pkg.sv
// mcode_pkg: shared encodings for the microcode sequencer.
// Op codes, microword field layout and FSM states.
package mcode_pkg;

  localparam int AW_D    = 6;
  localparam int CW_D    = 16;
  localparam int NCOND_D = 4;
  localparam int DEPTH_D = 2;

  localparam int TGT_LSB = 0;
  localparam int OP_LSB  = 6;
  localparam int OP_W    = 3;
  localparam int SEL_LSB = 9;
  localparam int SEL_W   = 2;
  localparam int CTL_LSB = 11;
  localparam int ZW      = CTL_LSB + CW_D;

  localparam logic [OP_W-1:0] OP_CONT = 3'd0;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
  localparam logic [OP_W-1:0] OP_JCC  = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;
  localparam logic [OP_W-1:0] OP_WAIT = 3'd5;
  localparam logic [OP_W-1:0] OP_HALT = 3'd6;
  localparam logic [OP_W-1:0] OP_JNC  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/mcode_stack.sv
// mcode_stack: small return-address LIFO.
// Push/pop ignored when full/empty; clr empties it.
module mcode_stack #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CNTW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(cnt_q) == i + 1) dout = mem_q[i];
  end

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (int'(cnt_q) == i) mem_d[i] = din;
      cnt_d = cnt_q + CNTW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/mcode_seq.sv
// mcode_seq: microcode sequencer driving a registered 64-word ROM.
// Advances only on rising edges of the phase strobe clk.
module mcode_seq
  import mcode_pkg::*;
#(
  parameter int AW          = AW_D,
  parameter int CW          = CW_D,
  parameter int NCOND       = NCOND_D,
  parameter int STACK_DEPTH = DEPTH_D
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             clk,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [NCOND-1:0] cond,
  input  logic [ZW-1:0]    z,
  output logic [AW-1:0]    a,
  output logic [CW-1:0]    ctl,
  output logic             ctl_vld,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_e              state_q, state_d;
  logic                clk_prev_q;
  logic [AW-1:0]       a_q, a_d;
  logic [CW-1:0]       ctl_q, ctl_d;
  logic                ctl_vld_q, ctl_vld_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wait_q, wait_d;

  logic                tick, c, issue;
  logic [OP_W-1:0]     op;
  logic [SEL_W-1:0]    sel;
  logic [AW-1:0]       tgt, a_inc, top;
  logic                push, pop, clr, full, empty;

  assign tick  = ~clk_prev_q & clk;
  assign tgt   = z[TGT_LSB +: AW];
  assign op    = z[OP_LSB +: OP_W];
  assign sel   = z[SEL_LSB +: SEL_W];
  assign c     = cond[sel];
  assign a_inc = a_q + AW'(1);

  mcode_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (AW)
  ) u_stack (
    .clk   (sys_clk),
    .rst_n (resetl),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (a_inc),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    ctl_d     = ctl_q;
    ctl_vld_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    wait_d    = wait_q;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    issue     = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          a_d     = start_addr;
          err_d   = 1'b0;
          clr     = 1'b1;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          wait_d  = 1'b0;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          // a stalled WAIT re-evaluates but issues its ctl only once
          issue   = ~wait_q;
          state_d = S_FETCH;
          unique case (op)
            OP_CONT: a_d = a_inc;
            OP_JMP:  a_d = tgt;
            OP_JCC:  a_d = c ? tgt : a_inc;
            OP_JNC:  a_d = c ? a_inc : tgt;
            OP_CALL: if (full) begin
              err_d   = 1'b1;
              issue   = 1'b0;
              state_d = S_IDLE;
            end else begin
              push = 1'b1;
              a_d  = tgt;
            end
            OP_RET: if (empty) begin
              err_d   = 1'b1;
              issue   = 1'b0;
              state_d = S_IDLE;
            end else begin
              pop = 1'b1;
              a_d = top;
            end
            OP_WAIT: if (c) begin
              a_d = a_inc;
            end else begin
              wait_d  = 1'b1;
              state_d = S_EXEC;
            end
            OP_HALT: begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
            default: ;
          endcase
          if (issue) begin
            ctl_d     = z[CTL_LSB +: CW];
            ctl_vld_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q    <= S_IDLE;
      clk_prev_q <= 1'b1;
      a_q        <= '0;
      ctl_q      <= '0;
      ctl_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_prev_q <= clk;
      a_q        <= a_d;
      ctl_q      <= ctl_d;
      ctl_vld_q  <= ctl_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  assign a       = a_q;
  assign ctl     = ctl_q;
  assign ctl_vld = ctl_vld_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule
